// File: rtl/fifo_dp_ctrl.sv
// fifo_dp_ctrl: single-clock FIFO controller driving an external asynchronous dual-port RAM.
//   Port 0 of the RAM is used only for writes, port 1 only for reads.
//   clk, rst (async, active high)
//   wr_en/wr_data          : write request and word
//   rd_en/rd_data/rd_valid : read request, returned word, and its one-cycle qualifier
//   full/empty/almost_full/count : occupancy status, all registered
//   overflow/underflow     : one-cycle pulses for rejected write/read
//   address_0/cs_0/we_0/oe_0/ram_wdata : RAM write port
//   address_1/cs_1/we_1/oe_1/ram_rdata : RAM read port
module fifo_dp_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH-1:0] address_0,
    output logic                  cs_0,
    output logic                  we_0,
    output logic                  oe_0,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] address_1,
    output logic                  cs_1,
    output logic                  we_1,
    output logic                  oe_1,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] AF    = (ADDR_WIDTH+1)'(AF_LEVEL);

    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic                  wr_ok, rd_ok;
    logic [ADDR_WIDTH:0]   count_nxt;

    // Acceptance uses the registered count only, so a word written at edge E
    // cannot be read-strobed before its own write strobe has completed.
    always_comb begin
        wr_ok     = wr_en && (count != DEPTH);
        rd_ok     = rd_en && (count != '0);
        count_nxt = (wr_ok && !rd_ok) ? count + 1'b1 :
                    (rd_ok && !wr_ok) ? count - 1'b1 : count;
    end

    assign we_1 = 1'b0;
    assign oe_0 = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            address_0   <= '0;
            ram_wdata   <= '0;
            cs_0        <= 1'b0;
            we_0        <= 1'b0;
            address_1   <= '0;
            cs_1        <= 1'b0;
            oe_1        <= 1'b0;
        end else begin
            wptr        <= wptr + ADDR_WIDTH'(wr_ok);
            rptr        <= rptr + ADDR_WIDTH'(rd_ok);
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == DEPTH);
            almost_full <= (count_nxt >= AF);
            overflow    <= wr_en && !wr_ok;
            underflow   <= rd_en && !rd_ok;
            cs_0        <= wr_ok;
            we_0        <= wr_ok;
            // Address/data hold between strobes so the async RAM never sees a glitch.
            if (wr_ok) begin
                address_0 <= wptr;
                ram_wdata <= wr_data;
            end
            cs_1 <= rd_ok;
            oe_1 <= rd_ok;
            if (rd_ok)
                address_1 <= rptr;
            // Data is captured at the end of the one-cycle read strobe.
            rd_valid <= cs_1;
            if (cs_1)
                rd_data <= ram_rdata;
        end
    end
endmodule
